sinegen_dds: RTL and testbench

- Parametrised direct-digital-synthesis sine generator; next generation of the counter-plus-ROM sine generator.
- A phase accumulator with a programmable increment replaces the fixed +1 address counter.
- Drives two outputs from one dual-port sine ROM: channel 1 at accumulator phase, channel 2 at a programmable phase offset.
- Adds sample-valid, phase sync, and hold-on-disable behaviour; sits between control logic and DAC/display sinks.

---
 rtl/sinegen_pkg.sv | 30 +++
 rtl/sine_rom_dp.sv | 33 +++
 rtl/sinegen_dds.sv | 75 +++++++
 tb/tb_sinegen_dds.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sinegen_pkg.sv
// rtl/sinegen_pkg.sv - shared widths, ROM defaults and phase helpers for the DDS sine generator
package sinegen_pkg;

    localparam int    DEF_A_WIDTH   = 8;
    localparam int    DEF_D_WIDTH   = 8;
    localparam int    DEF_ACC_WIDTH = 16;
    localparam string DEF_ROM_FILE  = "sinerom.mem";

    localparam real   TWO_PI        = 6.283185307179586;

    // Top a_width bits of the accumulator form the ROM address (truncation, no rounding).
    function automatic int unsigned phase_addr(logic [31:0] acc, int acc_width, int a_width);
        logic [31:0] shifted;
        shifted = acc >> (acc_width - a_width);
        return int'(shifted & ((32'd1 << a_width) - 32'd1));
    endfunction

    // One ROM word: round(amp + amp*sin(2*pi*idx/depth)), amp = 2**(d_width-1)-1.
    // Only ever called with elaboration-time constants, so it folds to a constant table.
    function automatic int unsigned sine_word(int idx, int a_width, int d_width);
        real amp;
        real phase;
        real sample;
        amp    = real'((1 << (d_width - 1)) - 1);
        phase  = TWO_PI * real'(idx) / real'(1 << a_width);
        sample = amp + amp * $sin(phase) + 0.5;
        return int'($rtoi(sample));
    endfunction

endpackage

// File: rtl/sine_rom_dp.sv
// rtl/sine_rom_dp.sv - dual-port synchronous-read sine ROM with shared read enable
module sine_rom_dp
    import sinegen_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               re,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [A_WIDTH-1:0] addr2,
    output logic [D_WIDTH-1:0] dout1,
    output logic [D_WIDTH-1:0] dout2
);

    localparam int DEPTH = 1 << A_WIDTH;

    logic [D_WIDTH-1:0] rom [DEPTH];

    // Constant sine table, one word per address; synthesises to ROM contents.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = D_WIDTH'(sine_word(i, A_WIDTH, D_WIDTH));
    end

    // Registered read on both ports; outputs hold whenever re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            dout1 <= rom[addr1];
            dout2 <= rom[addr2];
        end
    end

endmodule

// File: rtl/sinegen_dds.sv
// rtl/sinegen_dds.sv - DDS sine generator: phase accumulator driving a dual-port sine ROM
module sinegen_dds
    import sinegen_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter     ROM_FILE  = DEF_ROM_FILE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [ACC_WIDTH-1:0] incr,
    input  logic [A_WIDTH-1:0]   offset,
    output logic [D_WIDTH-1:0]   dout1,
    output logic [D_WIDTH-1:0]   dout2,
    output logic                 valid
);

    logic [ACC_WIDTH-1:0] acc;
    logic [A_WIDTH-1:0]   addr1;
    logic [A_WIDTH-1:0]   addr2;
    logic                 advance;
    logic                 primed;
    logic [D_WIDTH-1:0]   rom_q1;
    logic [D_WIDTH-1:0]   rom_q2;

    // Reset blocks the ROM read so no sample is captured on a reset edge.
    assign advance = en & ~rst;

    // Both addresses come from the pre-edge accumulator; channel 2 wraps modulo depth.
    assign addr1 = A_WIDTH'(phase_addr(32'(acc), ACC_WIDTH, A_WIDTH));
    assign addr2 = addr1 + offset;

    // Phase accumulator: reset and sync restart phase, otherwise step by incr when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (sync) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + incr;
        end
    end

    // One-cycle valid strobe per sample; primed masks the unreset ROM registers until the first sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            primed <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                primed <= 1'b1;
            end
        end
    end

    sine_rom_dp #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_rom (
        .clk   (clk),
        .re    (advance),
        .addr1 (addr1),
        .addr2 (addr2),
        .dout1 (rom_q1),
        .dout2 (rom_q2)
    );

    assign dout1 = primed ? rom_q1 : '0;
    assign dout2 = primed ? rom_q2 : '0;

endmodule

// File: tb/tb_sinegen_dds.sv
// tb/tb_sinegen_dds.sv - scoreboard testbench for sinegen_dds
module tb_sinegen_dds;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] incr = 16'h0000;
    logic [7:0]  offset = 8'h00;
    logic [7:0]  dout1;
    logic [7:0]  dout2;
    logic        valid;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] macc = 16'h0000;
    logic [7:0]  held1 = 8'h00;
    logic [7:0]  held2 = 8'h00;
    logic        rst_q = 1'b0;
    logic        started = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    sinegen_dds #(
        .A_WIDTH   (8),
        .D_WIDTH   (8),
        .ACC_WIDTH (16),
        .ROM_FILE  ("sinerom.mem")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .incr   (incr),
        .offset (offset),
        .dout1  (dout1),
        .dout2  (dout2),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_rom(int idx);
        real v;
        v = 127.0 + 127.0 * $sin(6.283185307179586 * real'(idx % 256) / 256.0);
        return 8'($rtoi(v + 0.5));
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop one expected pair per valid sample, else outputs must hold.
    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            started = 1'b1;
            check("reset_valid", int'(valid), 0);
            check("reset_dout1", int'(dout1), 0);
            check("reset_dout2", int'(dout2), 0);
            held1 = 8'h00;
            held2 = 8'h00;
        end else if (started) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    check("sample_dout1", int'(dout1), int'(e.d1));
                    check("sample_dout2", int'(dout2), int'(e.d2));
                    held1 = e.d1;
                    held2 = e.d2;
                end
            end else begin
                check("hold_dout1", int'(dout1), int'(held1));
                check("hold_dout2", int'(dout2), int'(held2));
            end
        end
    end

    // Drive one edge; when a sample is due, push its expectation (model or hand value).
    task automatic drive(input bit e, input bit s, input bit r,
                         input bit hand, input int h1, input int h2);
        pair_t p;
        logic [7:0] a1;
        en   = e;
        sync = s;
        rst  = r;
        if (r) begin
            macc = 16'h0000;
        end else begin
            if (e) begin
                a1 = macc[15:8];
                if (hand) begin
                    p.d1 = 8'(h1);
                    p.d2 = 8'(h2);
                end else begin
                    p.d1 = ref_rom(int'(a1));
                    p.d2 = ref_rom(int'(8'(a1 + offset)));
                end
                exp_q.push_back(p);
            end
            if (s) macc = 16'h0000;
            else if (e) macc = macc + incr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic reset1();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        // Reset for two cycles, then idle with outputs at zero
        reset1();
        reset1();
        idle(3);

        // Basic sweep, offset 0, wraps past address 255
        incr   = 16'h0100;
        offset = 8'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        run(259);
        idle(2);

        // Quarter-wave offset on channel 2
        reset1();
        offset = 8'd64;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 254);
        run(63);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 254, 127);
        run(5);

        // Quarter-rate tone, then half-step, then a mid-run increment change
        reset1();
        offset = 8'd0;
        incr   = 16'h4000;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 254, 254);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        end
        reset1();
        incr = 16'h0080;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        run(8);
        incr = 16'h0300;
        run(6);
        incr = 16'h0000;
        run(3);

        // Enable gating at address 10: hold ROM[9], resume at ROM[10]
        reset1();
        incr = 16'h0100;
        run(10);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 158, 158);
        run(2);

        // Sync at address 100, then sync+reset together, then reset mid-sweep
        reset1();
        run(100);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 208, 208);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        run(4);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        run(20);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 127);
        run(3);

        // Aliasing increment is legal
        incr = 16'hC000;
        run(4);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
